// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - recovers BCD digits from a scanned active-low seven-segment bus
//
// Ports:
//   clock        rising-edge system clock
//   reset_n      asynchronous active-low reset; release is synchronised internally
//   seg_n        active-low segments, bit0 = a .. bit6 = g
//   digit_idx    digit position currently driven on seg_n
//   bcd_out      decoded digits, digit k at [4k+3:4k]
//   digit_valid  digit k holds a decoded or blank value
//   digit_blank  digit k was last accepted as blank
//   digit_update one-cycle pulse per accepted in-range sample
//   frame_done   one-cycle pulse when every position has been accepted since last frame
//   bad_pattern  one-cycle pulse when an undecodable pattern is accepted
//   err_count    saturating count of bad patterns
module seven_segment_scan_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int IDX_W         = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [6:0]              seg_n,
  input  logic [IDX_W-1:0]        digit_idx,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    digit_update,
  output logic                    frame_done,
  output logic                    bad_pattern,
  output logic [7:0]              err_count
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] K_DIGIT = 2'd0;
  localparam logic [1:0] K_BLANK = 2'd1;
  localparam logic [1:0] K_BAD   = 2'd2;

  typedef enum logic {SETTLE, HELD} state_t;

  // Returns {kind, value}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'h40:   r = {K_DIGIT, 4'd0};
      7'h79:   r = {K_DIGIT, 4'd1};
      7'h24:   r = {K_DIGIT, 4'd2};
      7'h30:   r = {K_DIGIT, 4'd3};
      7'h19:   r = {K_DIGIT, 4'd4};
      7'h12:   r = {K_DIGIT, 4'd5};
      7'h02:   r = {K_DIGIT, 4'd6};
      7'h78:   r = {K_DIGIT, 4'd7};
      7'h00:   r = {K_DIGIT, 4'd8};
      7'h10:   r = {K_DIGIT, 4'd9};
      7'h7F:   r = {K_BLANK, 4'd0};
      default: r = {K_BAD,   4'd0};
    endcase
    return r;
  endfunction

  // Reset release synchroniser; assertion still clears everything at once.
  logic [1:0] rst_pipe;
  logic       run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign run = rst_pipe[1];

  // Input synchroniser plus one more stage holding the previous pair.
  logic [6:0]       seg_s1, seg_s2, seg_prev;
  logic [IDX_W-1:0] idx_s1, idx_s2, idx_prev;
  logic             same;

  // State sits at its reset value until run rises, so holding is enough.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1   <= 7'h7F;
      seg_s2   <= 7'h7F;
      seg_prev <= 7'h7F;
      idx_s1   <= '0;
      idx_s2   <= '0;
      idx_prev <= '0;
    end else if (run) begin
      seg_s1   <= seg_n;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      idx_s1   <= digit_idx;
      idx_s2   <= idx_s1;
      idx_prev <= idx_s2;
    end
  end

  assign same = (seg_s2 == seg_prev) && (idx_s2 == idx_prev);

  // Stability filter FSM
  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic             accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= SETTLE;
      count <= '0;
    end else if (run) begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    accept   = 1'b0;
    case (state)
      SETTLE: begin
        if (!same) begin
          count_nx = '0;
        end else if (count == CNT_LAST) begin
          accept   = 1'b1;
          state_nx = HELD;
          count_nx = '0;
        end else begin
          count_nx = count + 1'b1;
        end
      end
      HELD: begin
        if (!same) begin
          state_nx = SETTLE;
          count_nx = '0;
        end
      end
      default: begin
        state_nx = SETTLE;
        count_nx = '0;
      end
    endcase
  end

  // Digit store and frame tracking
  logic [NUM_DIGITS-1:0]   seen, seen_nx, onehot;
  logic [4*NUM_DIGITS-1:0] bcd_nx;
  logic [NUM_DIGITS-1:0]   valid_nx, blank_nx;
  logic [7:0]              err_nx;
  logic                    upd_nx, frame_nx, bad_nx;
  logic [5:0]              dec;

  assign dec = decode(seg_s2);

  always_comb begin
    bcd_nx   = bcd_out;
    valid_nx = digit_valid;
    blank_nx = digit_blank;
    seen_nx  = seen;
    err_nx   = err_count;
    upd_nx   = 1'b0;
    frame_nx = 1'b0;
    bad_nx   = 1'b0;
    onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot[i] = (32'(idx_s2) == i);
    end
    // Out-of-range indices give an all-zero onehot and are dropped here.
    if (accept && (onehot != '0)) begin
      upd_nx = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (onehot[i]) begin
          case (dec[5:4])
            K_DIGIT: begin
              bcd_nx[4*i +: 4] = dec[3:0];
              valid_nx[i]      = 1'b1;
              blank_nx[i]      = 1'b0;
            end
            K_BLANK: begin
              bcd_nx[4*i +: 4] = 4'd0;
              valid_nx[i]      = 1'b1;
              blank_nx[i]      = 1'b1;
            end
            default: begin
              valid_nx[i] = 1'b0;
              blank_nx[i] = 1'b0;
            end
          endcase
        end
      end
      if (dec[5:4] == K_BAD) begin
        bad_nx = 1'b1;
        if (err_count != 8'hFF) err_nx = err_count + 8'd1;
      end
      if ((seen | onehot) == {NUM_DIGITS{1'b1}}) begin
        frame_nx = 1'b1;
        seen_nx  = '0;
      end else begin
        seen_nx = seen | onehot;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcd_out      <= '0;
      digit_valid  <= '0;
      digit_blank  <= '0;
      seen         <= '0;
      err_count    <= 8'd0;
      digit_update <= 1'b0;
      frame_done   <= 1'b0;
      bad_pattern  <= 1'b0;
    end else if (run) begin
      bcd_out      <= bcd_nx;
      digit_valid  <= valid_nx;
      digit_blank  <= blank_nx;
      seen         <= seen_nx;
      err_count    <= err_nx;
      digit_update <= upd_nx;
      frame_done   <= frame_nx;
      bad_pattern  <= bad_nx;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// tb/tb_seven_segment_scan_decoder.sv - scoreboard bench for seven_segment_scan_decoder
module tb_seven_segment_scan_decoder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [2:0]  digit_idx = 3'd7;
  logic [23:0] bcd_out;
  logic [5:0]  digit_valid, digit_blank;
  logic        digit_update, frame_done, bad_pattern;
  logic [7:0]  err_count;

  seven_segment_scan_decoder dut (
    .clock(clock), .reset_n(reset_n), .seg_n(seg_n), .digit_idx(digit_idx),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .digit_blank(digit_blank),
    .digit_update(digit_update), .frame_done(frame_done), .bad_pattern(bad_pattern),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] bcd;
    logic [5:0]  valid;
    logic [5:0]  blank;
    logic        frame;
    logic        badp;
    logic [7:0]  err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_got;
  int   total = 0;
  int   nbad = 0;
  int   frame_cnt = 0;

  logic [23:0] m_bcd = '0;
  logic [5:0]  m_valid = '0, m_blank = '0, m_seen = '0;
  logic [7:0]  m_err = '0;
  logic [9:0]  last_pair = {3'd7, 7'h7F};

  function automatic int tb_decode(input logic [6:0] p);
    case (p)
      7'h40: return 0;  7'h79: return 1;  7'h24: return 2;  7'h30: return 3;
      7'h19: return 4;  7'h12: return 5;  7'h02: return 6;  7'h78: return 7;
      7'h00: return 8;  7'h10: return 9;  7'h7F: return 10;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check(tag, {bcd_out, digit_valid, digit_blank, err_count},
          {m_bcd, m_valid, m_blank, m_err});
  endtask

  task automatic apply_model(input int idx, input logic [6:0] seg);
    int d;
    logic [5:0] oh;
    logic fr;
    if (idx < 6) begin
      d  = tb_decode(seg);
      oh = 6'b1 << idx;
      if (d < 0) begin
        m_valid[idx] = 1'b0;
        m_blank[idx] = 1'b0;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end else if (d == 10) begin
        m_bcd[4*idx +: 4] = 4'd0;
        m_valid[idx] = 1'b1;
        m_blank[idx] = 1'b1;
      end else begin
        m_bcd[4*idx +: 4] = d[3:0];
        m_valid[idx] = 1'b1;
        m_blank[idx] = 1'b0;
      end
      fr = ((m_seen | oh) == 6'h3F);
      m_seen = fr ? 6'h00 : (m_seen | oh);
      sb.push_back({m_bcd, m_valid, m_blank, fr, (d < 0), m_err});
    end
  endtask

  task automatic step(input int idx, input logic [6:0] seg, input int cycles);
    @(negedge clock);
    digit_idx = idx[2:0];
    seg_n = seg;
    if (cycles >= 7 && {idx[2:0], seg} != last_pair) apply_model(idx, seg);
    last_pair = {idx[2:0], seg};
    repeat (cycles) @(posedge clock);
  endtask

  always @(negedge clock) begin
    total++;
    assert (!((frame_done || bad_pattern) && !digit_update)) else begin
      nbad++;
      $error("FAIL orphan_pulse frame=%0b bad=%0b update=%0b", frame_done, bad_pattern, digit_update);
    end
    if (digit_update) begin
      if (frame_done) frame_cnt++;
      total++;
      assert (sb.size() != 0) else begin
        nbad++;
        $error("FAIL unexpected_update bcd=%h valid=%h got_size=0 exp_size>0", bcd_out, digit_valid);
      end
      if (sb.size() != 0) begin
        mon_e   = sb.pop_front();
        mon_got = {bcd_out, digit_valid, digit_blank, frame_done, bad_pattern, err_count};
        total++;
        assert (mon_got === mon_e) else begin
          nbad++;
          $error("FAIL update_record got=%h exp=%h", mon_got, mon_e);
        end
      end
    end
  end

  logic [6:0] scan_pat [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

  initial begin
    int lat, upd_n, f0;

    repeat (3) @(negedge clock);
    check("reset_state", {bcd_out, digit_valid, digit_blank, digit_update, frame_done, bad_pattern, err_count}, 64'd0);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);

    // 1: latency and single update
    @(negedge clock);
    digit_idx = 3'd0;
    seg_n = 7'h24;
    apply_model(0, 7'h24);
    last_pair = {3'd0, 7'h24};
    lat = 0;
    upd_n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (digit_update) begin
        upd_n++;
        if (lat == 0) lat = i;
      end
    end
    check("latency", lat, 7);
    check("single_update", upd_n, 1);
    check("digit0_value", {bcd_out[3:0], digit_valid[0]}, {4'd2, 1'b1});
    check("t1_no_frame", frame_cnt, 0);

    // 2: short glitch is not accepted
    step(1, 7'h30, 3);
    step(1, 7'h19, 8);
    check("t2_sb_empty", sb.size(), 0);
    check("digit1_value", bcd_out[7:4], 4'd4);
    check_model("t2_state");

    // 3: full scan
    f0 = frame_cnt;
    for (int k = 0; k < 6; k++) step(k, scan_pat[k], 8);
    check("scan_bcd", bcd_out, 24'h543210);
    check("scan_valid", digit_valid, 6'h3F);
    check("scan_frame", frame_cnt - f0, 1);

    // 4: bad pattern and saturation
    step(2, 7'h55, 8);
    check("bad_err1", err_count, 8'd1);
    check("bad_valid2", digit_valid[2], 1'b0);
    check("bad_digit2_kept", bcd_out[11:8], 4'd2);
    for (int r = 0; r < 300; r++) begin
      step(2, 7'h55, 8);
      step(2, 7'h40, 8);
    end
    check("err_saturated", err_count, 8'hFF);
    check_model("t4_state");

    // 5: blank and out-of-range index
    step(3, 7'h7F, 8);
    check("blank3", {digit_blank[3], digit_valid[3], bcd_out[15:12]}, {1'b1, 1'b1, 4'd0});
    step(7, 7'h40, 8);
    check("range_sb_empty", sb.size(), 0);
    check_model("range_state");

    // 6: reset mid-scan, then rescan
    for (int k = 0; k < 3; k++) step(k, scan_pat[k], 8);
    @(negedge clock);
    digit_idx = 3'd3;
    seg_n = 7'h30;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", {bcd_out, digit_valid, digit_blank, digit_update, frame_done, bad_pattern, err_count}, 64'd0);
    sb.delete();
    m_bcd = '0; m_valid = '0; m_blank = '0; m_seen = '0; m_err = '0;
    digit_idx = 3'd7;
    seg_n = 7'h7F;
    last_pair = {3'd7, 7'h7F};
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    f0 = frame_cnt;
    for (int k = 0; k < 5; k++) step(k, scan_pat[k], 8);
    check("rescan_no_early_frame", frame_cnt - f0, 0);
    step(5, scan_pat[5], 8);
    check("rescan_frame", frame_cnt - f0, 1);
    check("rescan_bcd", bcd_out, 24'h543210);

    repeat (4) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
